// File: rtl/sequential_pipelined_add.sv
// DEPTH-stage add-constant pipeline with bubble-collapsing ready/valid flow.
// Define SEQUENTIAL_PIPELINED_ADD_SATURATE_EN to saturate instead of wrap.
module sequential_pipelined_add #(
  parameter int          WIDTH     = 8,
  parameter int unsigned INCREMENT = 1,
  parameter int          DEPTH     = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CE,
  input  logic [WIDTH-1:0]           I0,
  input  logic                       valid_data_in,
  output logic                       ready_data_in,
  output logic [WIDTH-1:0]           O0,
  output logic                       valid_data_out,
  input  logic                       ready_data_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);

  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;
  logic [WIDTH-1:0] sum;
  logic             in_xfer;
  logic             out_xfer;

`ifdef SEQUENTIAL_PIPELINED_ADD_SATURATE_EN
  logic [WIDTH:0] sum_w;

  always_comb begin
    sum_w = {1'b0, I0} + {1'b0, INC};
    sum   = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
  end
`else
  always_comb sum = I0 + INC;
`endif

  // adv[i]: stage i may hand its word on, i.e. some later stage is
  // empty or the consumer is ready. Unrolled to avoid a comb loop.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = ready_data_out;
      for (int j = i + 1; j < DEPTH; j++)
        if (!v[j]) adv[i] = 1'b1;
      ld[i] = !v[i] || adv[i];
    end
  end

  always_comb begin
    up_v[0] = valid_data_in;
    up_d[0] = sum;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  assign ready_data_in  = CE && !RESET && ld[0];
  assign in_xfer        = valid_data_in && ready_data_in;
  assign out_xfer       = v[DEPTH-1] && ready_data_out && CE;
  assign valid_data_out = v[DEPTH-1];
  assign O0             = d[DEPTH-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        d[i] <= '0;
    end else if (CE) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) d[i] <= up_d[i];
        end
      end
      unique case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_pipelined_add.sv
// Scoreboard bench: three DUT configurations (D=2/W=8, D=1 and D=4 at W=16)
// driven by directed and random ready/valid/CE traffic.
module tb_sequential_pipelined_add;

  localparam int          W   [3] = '{8, 16, 16};
  localparam int unsigned INC [3] = '{1, 32'h1234, 32'h1234};
  localparam int          DEP [3] = '{2, 1, 4};

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic vin  [3];
  logic rout [3];
  logic [15:0] din [3];

  logic        rin  [3];
  logic        vout [3];
  logic [15:0] dout [3];
  logic [2:0]  cnt  [3];

  logic [7:0]  o_a;
  logic [15:0] o_b, o_c;
  logic [1:0]  c_a;
  logic [0:0]  c_b;
  logic [2:0]  c_c;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit nostall = 1'b0;

  int unsigned sb [3][$];
  int          ts [3][$];
  int unsigned last [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sequential_pipelined_add #(.WIDTH(8), .INCREMENT(1), .DEPTH(2)) u_a (
    .CLK(clk), .RESET(rst), .CE(ce), .I0(din[0][7:0]),
    .valid_data_in(vin[0]), .ready_data_in(rin[0]), .O0(o_a),
    .valid_data_out(vout[0]), .ready_data_out(rout[0]), .count(c_a));

  sequential_pipelined_add #(.WIDTH(16), .INCREMENT(32'h1234), .DEPTH(1)) u_b (
    .CLK(clk), .RESET(rst), .CE(ce), .I0(din[1]),
    .valid_data_in(vin[1]), .ready_data_in(rin[1]), .O0(o_b),
    .valid_data_out(vout[1]), .ready_data_out(rout[1]), .count(c_b));

  sequential_pipelined_add #(.WIDTH(16), .INCREMENT(32'h1234), .DEPTH(4)) u_c (
    .CLK(clk), .RESET(rst), .CE(ce), .I0(din[2]),
    .valid_data_in(vin[2]), .ready_data_in(rin[2]), .O0(o_c),
    .valid_data_out(vout[2]), .ready_data_out(rout[2]), .count(c_c));

  assign dout[0] = {8'h00, o_a};
  assign dout[1] = o_b;
  assign dout[2] = o_c;
  assign cnt[0]  = {1'b0, c_a};
  assign cnt[1]  = {2'b00, c_b};
  assign cnt[2]  = c_c;

  function automatic int unsigned model(input int k, input logic [15:0] x);
    int unsigned mask;
    int unsigned s;
    mask = (32'd1 << W[k]) - 32'd1;
    s = (32'(x) & mask) + INC[k];
`ifdef SEQUENTIAL_PIPELINED_ADD_SATURATE_EN
    return (s > mask) ? mask : s;
`else
    return s & mask;
`endif
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t",
               nm, k, got, exp, $time);
    end
  endtask

  task automatic mon_one(input int k);
    int unsigned e;
    int lat;
    chk("count", k, 32'(cnt[k]), sb[k].size());
    if (rst || !ce) chk("ready_gated", k, 32'(rin[k]), 0);
    if (sb[k].size() == 0) chk("vout_empty", k, 32'(vout[k]), 0);
    if (vout[k] && sb[k].size() > 0) chk("o0_head", k, dout[k], sb[k][0]);
    else if (!vout[k]) chk("o0_hold", k, dout[k], last[k]);
    if (rst) begin
      sb[k].delete();
      ts[k].delete();
      last[k] = 0;
    end else if (ce) begin
      if (vout[k] && rout[k] && sb[k].size() > 0) begin
        e = sb[k].pop_front();
        lat = cyc - ts[k].pop_front();
        last[k] = e;
        if (nostall) chk("latency", k, lat, DEP[k]);
        else chk("latency_min", k, (lat >= DEP[k]) ? 1 : 0, 1);
      end
      if (vin[k] && rin[k]) begin
        sb[k].push_back(model(k, din[k]));
        ts[k].push_back(cyc);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (chk_en)
        for (int k = 0; k < 3; k++) mon_one(k);
    end
  endtask

  // Called at a falling edge: latch accepts, advance to just after the edge.
  task automatic cycle_end();
    logic acc [3];
    for (int k = 0; k < 3; k++) acc[k] = vin[k] && rin[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      if (acc[k]) din[k] = din[k] + 16'd1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_end();
    end
  endtask

  task automatic set_all(input logic v, input logic r);
    for (int k = 0; k < 3; k++) begin
      vin[k] = v;
      rout[k] = r;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    set_all(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      last[k] = 0;
    end
    fork
      monitor();
    join_none

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_o0", 0, 32'(o_a), 0);
    chk("rst_vout", 0, 32'(vout[0]), 0);
    chk("rst_count", 0, 32'(c_a), 0);
    chk("rst_ready", 0, 32'(rin[0]), 0);
    cycle_end();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, 32'(rin[0]), 1);
    cycle_end();

    // stream without stalls
    nostall = 1'b1;
    for (int k = 0; k < 3; k++) din[k] = 16'h0010;
    set_all(1'b1, 1'b1);
    @(negedge clk);
    cycle_end();
    @(negedge clk);
    chk("first_vout_early", 0, 32'(vout[0]), 0);
    cycle_end();
    @(negedge clk);
    chk("first_vout", 0, 32'(vout[0]), 1);
    chk("first_o0", 0, 32'(o_a), model(0, 16'h0010));
    chk("peak_count", 0, 32'(c_a), 2);
    cycle_end();
    set_all(1'b0, 1'b1);
    run(6);
    nostall = 1'b0;

    // backpressure
    din[0] = 16'h0020;
    vin[0] = 1'b1;
    rout[0] = 1'b0;
    run(2);
    @(negedge clk);
    chk("bp_ready", 0, 32'(rin[0]), 0);
    chk("bp_count", 0, 32'(c_a), 2);
    chk("bp_o0", 0, 32'(o_a), model(0, 16'h0020));
    cycle_end();
    @(negedge clk);
    chk("bp_o0_stable", 0, 32'(o_a), model(0, 16'h0020));
    cycle_end();
    rout[0] = 1'b1;
    @(negedge clk);
    chk("full_ready", 0, 32'(rin[0]), 1);
    cycle_end();
    @(negedge clk);
    chk("full_count", 0, 32'(c_a), 2);
    cycle_end();
    vin[0] = 1'b0;
    run(4);

    // wrap / saturate
    din[0] = 16'h00FF;
    vin[0] = 1'b1;
    @(negedge clk);
    cycle_end();
    din[0] = 16'h00FE;
    @(negedge clk);
    cycle_end();
    vin[0] = 1'b0;
    @(negedge clk);
    chk("wrap_ff", 0, 32'(o_a), model(0, 16'h00FF));
    cycle_end();
    @(negedge clk);
    chk("wrap_fe", 0, 32'(o_a), 32'h00FF);
    cycle_end();
    run(3);

    // CE gating mid-stream
    din[0] = 16'h0040;
    set_all(1'b1, 1'b1);
    for (int c = 0; c < 9; c++) begin
      ce = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (!ce) chk("ce_ready", 0, 32'(rin[0]), 0);
      cycle_end();
    end
    ce = 1'b1;
    set_all(1'b0, 1'b1);
    run(6);

    // reset with words in flight
    din[0] = 16'h0050;
    vin[0] = 1'b1;
    rout[0] = 1'b0;
    run(2);
    vin[0] = 1'b0;
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vout", 0, 32'(vout[0]), 0);
    chk("mid_rst_o0", 0, 32'(o_a), 0);
    chk("mid_rst_count", 0, 32'(c_a), 0);
    cycle_end();
    rout[0] = 1'b1;
    run(4);

    // random traffic on all configurations
    for (int c = 0; c < 800; c++) begin
      ce = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < 3; k++) begin
        vin[k] = ($urandom_range(0, 2) != 0);
        rout[k] = ($urandom_range(0, 3) != 0);
        din[k] = 16'($urandom);
      end
      @(negedge clk);
      cycle_end();
    end
    ce = 1'b1;
    set_all(1'b0, 1'b1);
    run(8);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("drained", k, sb[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
